// File: rtl/mc_mp_ctrl_pkg.sv
// Shared types and constants for the multi-channel memory controller.
// Default parameter values live here so the controller, interface and bench agree.
package mc_pkg;

  // Width needed to index n items, never less than one bit.
  function automatic int mc_clog2(input int n);
    int w;
    w = 32'sd0;
    while ((32'sd1 << w) < n) begin
      w = w + 32'sd1;
    end
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

  localparam int MC_NUM_CH = 32'sd4;
  localparam int MC_ADDR_W = 32'sd4;
  localparam int MC_DEPTH  = 32'sd12;
  localparam int MC_DATA_W = 32'sd32;
  localparam int MC_RD_LAT = 32'sd2;
  localparam int MC_CH_W   = mc_clog2(MC_NUM_CH);

  // Observed read response at the default configuration.
  typedef struct packed {
    logic [MC_CH_W-1:0]   ch;
    logic [MC_DATA_W-1:0] rdata;
    logic                 err;
  } mc_rsp_t;

  typedef enum logic {
    MC_RD = 1'b0,
    MC_WR = 1'b1
  } mc_op_e;

endpackage

// File: rtl/mc_mp_ctrl_if.sv
// Request/response bundle between requestors (master) and the controller (slave).
// Channel i of each flattened field sits at [i*W +: W].
interface mc_mp_ctrl_if
  import mc_pkg::*;
#(
  parameter int NUM_CH = MC_NUM_CH,
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DATA_W = MC_DATA_W
);
  localparam int CH_W = mc_clog2(NUM_CH);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_wr;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH*BE_W-1:0]   req_be;
  logic                     rsp_valid;
  logic [CH_W-1:0]          rsp_ch;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_ch, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_ch, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mc_mp_ctrl_arbiter.sv
// Round-robin arbiter: grants the first requesting channel at or above the
// pointer (wrapping), and moves the pointer past the winner when told to advance.
module mc_rr_arbiter
  import mc_pkg::*;
#(
  parameter  int NUM_CH = MC_NUM_CH,
  localparam int CH_W   = mc_clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;
  logic            found;
  int              idx;

  // Rotating priority search starting at the pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 32'sd0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr_q) + k) % NUM_CH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
      end else begin
        found = found;
      end
    end
  end

  // Next pointer: one past the winner on a transfer, otherwise unchanged.
  always_comb begin
    if (advance) begin
      if (grant_idx == CH_W'(NUM_CH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + CH_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mc_mp_ctrl.sv
// Multi-channel register-file controller: round-robin request arbitration,
// byte-enabled writes and fixed-latency, channel-tagged read responses.
module mc_mp_ctrl
  import mc_pkg::*;
#(
  parameter int NUM_CH = MC_NUM_CH,
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DEPTH  = MC_DEPTH,
  parameter int DATA_W = MC_DATA_W,
  parameter int RD_LAT = MC_RD_LAT
) (
  input  logic        clk,
  input  logic        reset,
  mc_mp_ctrl_if.slave bus
);

  localparam int CH_W = mc_clog2(NUM_CH);
  localparam int BE_W = DATA_W / 8;

  // One read-pipeline slot; an empty slot is all zeros so idle outputs are 0.
  typedef struct packed {
    logic              vld;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } pipe_t;

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              accept;
  logic              wr_fire;
  logic              rd_fire;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_wr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_inrange;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  pipe_t             pipe_q [RD_LAT];
  pipe_t             pipe_d [RD_LAT];

  mc_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready follows the grant combinationally but is held off during reset.
  always_comb begin
    if (reset) begin
      bus.req_ready = '0;
    end else begin
      bus.req_ready = grant;
    end
  end

  assign accept = |bus.req_ready;

  // Select the granted channel's request fields and look up the current word.
  always_comb begin
    acc_addr    = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    acc_wdata   = bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    acc_be      = bus.req_be[int'(grant_idx)*BE_W +: BE_W];
    acc_wr      = bus.req_wr[grant_idx];
    acc_inrange = (int'(acc_addr) < DEPTH);
    rd_word     = '0;
    for (int w = 0; w < DEPTH; w++) begin
      if (acc_addr == ADDR_W'(w)) begin
        rd_word = mem_q[w];
      end else begin
        rd_word = rd_word;
      end
    end
  end

  assign wr_fire = accept & acc_wr & acc_inrange;
  assign rd_fire = accept & ~acc_wr;

  // Byte-masked write into the addressed word; out-of-range writes match no word.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < DEPTH; w++) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wr_fire && (acc_addr == ADDR_W'(w)) && acc_be[k]) begin
          mem_d[w][8*k +: 8] = acc_wdata[8*k +: 8];
        end else begin
          mem_d[w][8*k +: 8] = mem_q[w][8*k +: 8];
        end
      end
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read data is captured at the accept edge and then shifted RD_LAT-1 more times.
  always_comb begin
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_d[i] = '0;
    end
    if (rd_fire) begin
      pipe_d[0].vld   = 1'b1;
      pipe_d[0].ch    = grant_idx;
      pipe_d[0].rdata = acc_inrange ? rd_word : '0;
      pipe_d[0].err   = ~acc_inrange;
    end else begin
      pipe_d[0] = '0;
    end
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Read pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign bus.rsp_valid = pipe_q[RD_LAT-1].vld;
  assign bus.rsp_ch    = pipe_q[RD_LAT-1].ch;
  assign bus.rsp_rdata = pipe_q[RD_LAT-1].rdata;
  assign bus.rsp_err   = pipe_q[RD_LAT-1].err;

endmodule

// File: doc/mc_mp_ctrl.md
Name: mc_mp_ctrl

Overview:
Multi-channel memory controller. It is the parametrised successor of the single-port 2-bit-address/8-bit-data controller.
- NUM_CH requestors share one register-based memory of DEPTH words through a round-robin arbiter with valid/ready handshakes.
- Writes support byte enables. Reads return data after a fixed, parametrised latency, tagged with the originating channel.
- Out-of-range addresses are flagged with an error bit.
- Sits between the bus-side agents and the storage array.

Parameters:
NUM_CH, 4, number of requestor channels (1..16)
ADDR_W, 4, address width per channel
DEPTH, 12, implemented words; DEPTH <= 2**ADDR_W, need not be a power of two
DATA_W, 32, word width; multiple of 8
RD_LAT, 2, cycles from read accept edge to rsp_valid (>= 1)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_CH  per-channel request valid
req_ready  output  NUM_CH  per-channel accept (one-hot or zero)
req_wr  input  NUM_CH  1 = write, 0 = read
req_addr  input  NUM_CH*ADDR_W  flattened addresses, channel i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_CH*DATA_W  flattened write data
req_be  input  NUM_CH*DATA_W/8  flattened byte enables
rsp_valid  output  1  read response valid, single-cycle pulse
rsp_ch  output  CH_W  channel of response, CH_W = max(1, clog2(NUM_CH))
rsp_rdata  output  DATA_W  read data
rsp_err  output  1  response address was >= DEPTH

Behaviour:
- Reset: memory cleared to 0, rr pointer = 0, read pipeline flushed. rsp_valid, rsp_ch, rsp_rdata, rsp_err = 0. req_ready = 0 while reset is high.
- Arbitration:
  - At most one request is accepted per cycle.
  - Grant = first channel with req_valid=1, searching from the rr pointer upward with wrap-around from NUM_CH-1 to 0.
  - req_ready[grant] = 1 combinationally in the same cycle. The transfer occurs at the posedge where valid && ready.
  - After a grant, pointer <= grant+1 mod NUM_CH. With no valid request, the pointer holds.
- Handshake: a requestor holds valid, wr, addr, wdata and be stable until ready. Dropping valid before ready is legal; no state is kept for that request.
- Write accept, addr < DEPTH: byte k of mem[addr] is updated at the accept edge iff be[k]=1. No response is generated.
- Write accept, addr >= DEPTH: write is discarded, no response, no error signalled.
- Write with be = 0: no change.
- Read accept:
  - Entry {ch, addr, inrange} enters an RD_LAT-deep shift pipeline.
  - Data is sampled from memory at the accept edge, so read-after-write on a later cycle returns the new data.
  - rsp_valid pulses exactly RD_LAT cycles after the accept edge, with rsp_ch = channel.
  - addr >= DEPTH: rsp_rdata = 0, rsp_err = 1.
  - Otherwise rsp_err = 0.
- Back-to-back reads give one response per cycle, in acceptance order. There is no response backpressure.
- When rsp_valid = 0, rsp_ch, rsp_rdata and rsp_err are driven to 0.
- Reset mid-operation: all in-flight reads are dropped (no rsp_valid after reset is asserted) and memory is cleared.

Decomposition:
- Package mc_pkg holds:
  - the clog2-derived width constant helper
  - typedef mc_rsp_t {ch, rdata, err} for the pipeline entry and monitor
  - enum mc_op_e {MC_RD, MC_WR} for bench use
- Sub-module mc_rr_arbiter (parameter NUM_CH): inputs clk, reset, req[NUM_CH], advance; outputs grant one-hot and grant index. Owns the rr pointer.

Test Plan:
- Reset values: hold reset 3 cycles with all channels valid -> req_ready = 0, rsp_valid = 0. After release, all 12 words read back 0 with rsp_err = 0.
- Latency: ch0 writes addr 3 = 0xDEADBEEF with be = 4'hF; next cycle ch0 reads addr 3 -> rsp_valid exactly 2 cycles after the read accept, rsp_ch = 0, rsp_rdata = 0xDEADBEEF.
- Byte enables: write 0x11223344 to addr 5 with be = 4'hF, then 0xAABBCCDD with be = 4'b0101 -> read returns 0x11BB33DD.
- Fairness: all 4 channels hold valid reads continuously for 8 cycles from a fresh reset -> grant order 0,1,2,3,0,1,2,3. Responses carry rsp_ch in the same order, one per cycle.
- Out of range: ch2 reads addr 13 -> rsp_err = 1, rsp_rdata = 0, rsp_ch = 2. A write to addr 15 is discarded and leaves addrs 0..11 unchanged.
- Reset mid-read: read accepted, reset asserted the next cycle -> no rsp_valid ever appears for that read, and the memory reads 0 afterwards.
